// File: rtl/dft_scan_ctrl_pkg.sv
// Shared definitions for the DFT scan sequencer: state set, word width, default sizes.
package dft_scan_ctrl_pkg;

  localparam int unsigned DFT_WORD_W    = 32;
  localparam int unsigned DEF_CHAIN_LEN = 2048;
  localparam int unsigned DEF_ACK_TO    = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ARM,
    ST_SHIFT,
    ST_FLUSH,
    ST_RESP
  } scan_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/dft_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module dft_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dft_scan_ctrl.sv
// Sequencer upstream of dft_datapath: functional run, buffer arm, scan shift, flush,
// then a val/rdy response with committed word count and error status.
module dft_scan_ctrl
  import dft_scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned ACK_TO    = DEF_ACK_TO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [CYC_W-1:0] cmd_cycles,
  input  logic             cmd_dump,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [7:0]       resp_words,
  output logic             resp_err,
  output logic             dut_ce,
  output logic             sc_sen,
  output logic             buf_op,
  output logic             buf_val_op,
  output logic             buf_sin_sel,
  input  logic             buf_op_ack,
  input  logic             buf_op_commit,
  input  logic             buf_scaning
);

  localparam int unsigned SH_W      = $clog2(CHAIN_LEN);
  localparam int unsigned ATO_W     = $clog2(ACK_TO + 1);
  localparam logic [31:0] EXP_WORDS = 32'(CHAIN_LEN / DFT_WORD_W);

  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic             r_dump;
  logic [7:0]       r_words;
  logic             r_err;
  logic [ATO_W-1:0] r_ack_cnt;
  logic             r_dut_ce;
  logic             r_sc_sen;
  logic             r_buf_op;
  logic             r_resp_val;

  logic             w_accept;
  logic             w_run_zero;
  logic             w_sh_zero;
  logic             w_sh_load;
  logic             w_timeout;
  logic             w_cnt_en;
  logic [7:0]       w_words_inc;
  logic             w_err_nxt;

  assign w_accept  = (r_state == ST_IDLE) && cmd_val;
  assign w_sh_load = (r_state == ST_ARM) && buf_op_ack;

  // Both counters are loaded with length-1 so the state is held exactly `length` cycles.
  dft_down_counter #(.W(CYC_W)) u_run_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_accept),
    .i_load_val (cmd_cycles - CYC_W'(1)),
    .i_dec      (r_state == ST_RUN),
    .o_zero     (w_run_zero)
  );

  dft_down_counter #(.W(SH_W)) u_shift_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_sh_load),
    .i_load_val (SH_W'(CHAIN_LEN - 1)),
    .i_dec      (r_state == ST_SHIFT),
    .o_zero     (w_sh_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_val) begin
          if (cmd_cycles != '0) w_state_nxt = ST_RUN;
          else if (cmd_dump)    w_state_nxt = ST_ARM;
          else                  w_state_nxt = ST_RESP;
        end
      end
      ST_RUN: begin
        if (w_run_zero) w_state_nxt = r_dump ? ST_ARM : ST_RESP;
      end
      ST_ARM: begin
        if (buf_op_ack) begin
          w_state_nxt = ST_SHIFT;
        end else if (r_ack_cnt == ATO_W'(ACK_TO - 1)) begin
          w_state_nxt = ST_RESP;
          w_timeout   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_sh_zero) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!buf_scaning) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cnt_en    = buf_op_commit &&
                       ((r_state == ST_ARM) || (r_state == ST_SHIFT) || (r_state == ST_FLUSH));
  assign w_words_inc = sat_inc8(r_words, w_cnt_en);
  assign w_err_nxt   = r_err || w_timeout ||
                       ((r_state == ST_FLUSH) && (w_state_nxt == ST_RESP) &&
                        ({24'd0, w_words_inc} != EXP_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_cnt <= '0;
    end else if (r_state == ST_ARM) begin
      r_ack_cnt <= r_ack_cnt + ATO_W'(1);
    end else begin
      r_ack_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dump  <= 1'b0;
      r_words <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_dump  <= cmd_dump;
      r_words <= '0;
      r_err   <= 1'b0;
    end else begin
      r_words <= w_words_inc;
      r_err   <= w_err_nxt;
    end
  end

  // Outputs registered from the next state so each is high exactly while its state is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dut_ce   <= 1'b0;
      r_sc_sen   <= 1'b0;
      r_buf_op   <= 1'b0;
      r_resp_val <= 1'b0;
    end else begin
      r_dut_ce   <= (w_state_nxt == ST_RUN);
      r_sc_sen   <= (w_state_nxt == ST_SHIFT);
      r_buf_op   <= (w_state_nxt == ST_ARM);
      r_resp_val <= (w_state_nxt == ST_RESP);
    end
  end

  assign cmd_rdy     = (r_state == ST_IDLE);
  assign resp_val    = r_resp_val;
  assign resp_words  = r_words;
  assign resp_err    = r_err;
  assign dut_ce      = r_dut_ce;
  assign sc_sen      = r_sc_sen;
  assign buf_val_op  = r_sc_sen;
  assign buf_sin_sel = r_sc_sen;
  assign buf_op      = r_buf_op;

endmodule

// File: tb/tb_dft_scan_ctrl.sv
// Self-checking bench for dft_scan_ctrl: buffer-side responder plus outcome model per command.
module tb_dft_scan_ctrl;

  localparam int CHAIN_LEN = 2048;
  localparam int ACK_TO    = 64;
  localparam int WORDS     = CHAIN_LEN / 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [15:0] cmd_cycles;
  logic        cmd_dump;
  logic        resp_val;
  logic        resp_rdy;
  logic [7:0]  resp_words;
  logic        resp_err;
  logic        dut_ce;
  logic        sc_sen;
  logic        buf_op;
  logic        buf_val_op;
  logic        buf_sin_sel;
  logic        buf_op_ack;
  logic        buf_op_commit;
  logic        buf_scaning;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    int         n_ce;
    int         n_sen;
    int         n_bufop;
    int         n_resp;
    int         first_arm;
    int         viol;
    int         unstable;
    int         rdy_busy;
    logic [7:0] words;
    logic       err;
    bit         got_resp;
    bit         post_ok;
    bit         hung;
  } obs_t;

  typedef struct packed {
    int         n_ce;
    int         n_sen;
    int         n_bufop;
    int         first_arm;
    logic [7:0] words;
    logic       err;
  } exp_t;

  dft_scan_ctrl #(.CHAIN_LEN(CHAIN_LEN), .CYC_W(16), .ACK_TO(ACK_TO)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_val       (cmd_val),
    .cmd_rdy       (cmd_rdy),
    .cmd_cycles    (cmd_cycles),
    .cmd_dump      (cmd_dump),
    .resp_val      (resp_val),
    .resp_rdy      (resp_rdy),
    .resp_words    (resp_words),
    .resp_err      (resp_err),
    .dut_ce        (dut_ce),
    .sc_sen        (sc_sen),
    .buf_op        (buf_op),
    .buf_val_op    (buf_val_op),
    .buf_sin_sel   (buf_sin_sel),
    .buf_op_ack    (buf_op_ack),
    .buf_op_commit (buf_op_commit),
    .buf_scaning   (buf_scaning)
  );

  always #5 clk = ~clk;

  // Command outcome from the rules: run length, arm outcome, whole-chain shift, word count.
  function automatic exp_t model(input int cyc, input bit dump, input int ack_dly, input int drop_idx);
    exp_t e;
    bit   acked;
    acked       = dump && (ack_dly >= 1) && (ack_dly <= ACK_TO);
    e.n_ce      = cyc;
    e.first_arm = dump ? cyc : -1;
    e.n_bufop   = !dump ? 0 : (acked ? ack_dly : ACK_TO);
    e.n_sen     = acked ? CHAIN_LEN : 0;
    e.words     = acked ? 8'(WORDS - (((drop_idx >= 0) && (drop_idx < WORDS)) ? 1 : 0)) : 8'd0;
    e.err       = dump && (!acked || (int'(e.words) != WORDS));
    return e;
  endfunction

  // Issues one command, plays the buffer side, and records what the controller did.
  task automatic run_cmd(input int cyc, input bit dump, input int ack_dly, input int drop_idx,
                         input int tail, input int rdy_dly, input bit spurious, output obs_t o);
    int bits, commit_idx, tail_left, hold;
    bit pend, rdy_sent;
    o = '0;
    o.first_arm = -1;
    bits = 0; commit_idx = 0; tail_left = 0; hold = 0; pend = 0; rdy_sent = 0;
    @(posedge clk); #1;
    cmd_cycles = 16'(cyc);
    cmd_dump   = dump;
    cmd_val    = 1'b1;
    @(posedge clk); #1;
    cmd_val = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (rdy_sent) begin
        o.post_ok     = !resp_val && cmd_rdy;
        resp_rdy      = 1'b0;
        buf_op_ack    = 1'b0;
        buf_op_commit = 1'b0;
        buf_scaning   = 1'b0;
        return;
      end
      if (dut_ce) o.n_ce++;
      if (sc_sen) o.n_sen++;
      if (buf_op) begin
        o.n_bufop++;
        if (o.first_arm < 0) o.first_arm = k;
      end
      if ((dut_ce && sc_sen) || (sc_sen !== buf_val_op) || (sc_sen !== buf_sin_sel) ||
          (buf_op && (dut_ce || sc_sen || resp_val))) o.viol++;
      if (cmd_rdy) o.rdy_busy++;

      buf_op_ack    = buf_op && (ack_dly > 0) && (o.n_bufop == ack_dly);
      buf_op_commit = 1'b0;
      if (pend) begin
        if (commit_idx != drop_idx) buf_op_commit = 1'b1;
        commit_idx++;
        pend = 1'b0;
      end
      if (spurious && (dut_ce || resp_val)) buf_op_commit = 1'($urandom_range(0, 1));
      if (buf_val_op) begin
        bits++;
        if ((bits % 32) == 0) pend = 1'b1;
        tail_left   = tail;
        buf_scaning = 1'b1;
      end else if (tail_left > 0) begin
        tail_left--;
        buf_scaning = 1'b1;
      end else begin
        buf_scaning = 1'b0;
      end

      if (resp_val) begin
        o.n_resp++;
        if (!o.got_resp) begin
          o.got_resp = 1'b1;
          o.words    = resp_words;
          o.err      = resp_err;
        end else if ((resp_words !== o.words) || (resp_err !== o.err)) begin
          o.unstable++;
        end
        if (hold == rdy_dly) begin
          resp_rdy = 1'b1;
          rdy_sent = 1'b1;
        end else begin
          hold++;
        end
      end
      @(posedge clk); #1;
    end
    o.hung   = 1'b1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    bit seen;
    #12;
    n_vec++; if ({dut_ce, sc_sen, buf_op, buf_val_op, buf_sin_sel, resp_val, resp_words, resp_err} !== '0 || cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_por outputs=%b cmd_rdy=%b exp outputs=0 cmd_rdy=1", {dut_ce, sc_sen, buf_op, buf_val_op, buf_sin_sel, resp_val, resp_words, resp_err}, cmd_rdy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    cmd_cycles = 16'd2; cmd_dump = 1'b1; cmd_val = 1'b1;
    @(posedge clk); #1;
    cmd_val = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      buf_op_ack = buf_op;
      seen = sc_sen;
      if (!seen) begin @(posedge clk); #1; end
    end
    buf_op_ack = 1'b0;
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL reset_reach_shift sc_sen_seen=%0b exp=1", seen); end
    repeat (100) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_vec++; if ({dut_ce, sc_sen, buf_op, buf_val_op, buf_sin_sel, resp_val, resp_words, resp_err} !== '0 || cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_mid_shift outputs=%b cmd_rdy=%b exp outputs=0 cmd_rdy=1", {dut_ce, sc_sen, buf_op, buf_val_op, buf_sin_sel, resp_val, resp_words, resp_err}, cmd_rdy); end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_val || !cmd_rdy || dut_ce || sc_sen || buf_op) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL reset_no_resp bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_run_only();
    obs_t o;
    exp_t e;
    e = model(5, 1'b0, 0, -1);
    run_cmd(5, 1'b0, 0, -1, 0, 0, 1'b1, o);
    n_vec++; if (o.hung !== 1'b0) begin n_err++; $display("FAIL run_only timeout hung=%0b exp=0", o.hung); end
    n_vec++; if (o.n_ce !== e.n_ce) begin n_err++; $display("FAIL run_only ce_cycles got=%0d exp=%0d", o.n_ce, e.n_ce); end
    n_vec++; if (o.n_bufop !== e.n_bufop || o.n_sen !== e.n_sen) begin n_err++; $display("FAIL run_only scan_activity bufop=%0d sen=%0d exp 0/0", o.n_bufop, o.n_sen); end
    n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL run_only resp words=%0d err=%0b exp words=%0d err=%0b", o.words, o.err, e.words, e.err); end
    n_vec++; if (o.post_ok !== 1'b1 || o.rdy_busy !== 0) begin n_err++; $display("FAIL run_only handshake post_ok=%0b rdy_busy=%0d exp 1/0", o.post_ok, o.rdy_busy); end
  endtask

  task automatic test_full_dump();
    obs_t o;
    exp_t e;
    e = model(3, 1'b1, 2, -1);
    run_cmd(3, 1'b1, 2, -1, 2, 0, 1'b0, o);
    n_vec++; if (o.hung !== 1'b0) begin n_err++; $display("FAIL full_dump timeout hung=%0b exp=0", o.hung); end
    n_vec++; if (o.n_ce !== e.n_ce || o.first_arm !== e.first_arm) begin n_err++; $display("FAIL full_dump run ce=%0d arm_at=%0d exp ce=%0d arm_at=%0d", o.n_ce, o.first_arm, e.n_ce, e.first_arm); end
    n_vec++; if (o.n_bufop !== e.n_bufop) begin n_err++; $display("FAIL full_dump bufop_cycles got=%0d exp=%0d", o.n_bufop, e.n_bufop); end
    n_vec++; if (o.n_sen !== e.n_sen) begin n_err++; $display("FAIL full_dump sen_cycles got=%0d exp=%0d", o.n_sen, e.n_sen); end
    n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL full_dump resp words=%0d err=%0b exp words=%0d err=%0b", o.words, o.err, e.words, e.err); end
    n_vec++; if (o.viol !== 0) begin n_err++; $display("FAIL full_dump exclusion violations=%0d exp=0", o.viol); end
  endtask

  task automatic test_zero_run_dump();
    obs_t o;
    exp_t e;
    e = model(0, 1'b1, 5, -1);
    run_cmd(0, 1'b1, 5, -1, 0, 1, 1'b0, o);
    n_vec++; if (o.hung !== 1'b0) begin n_err++; $display("FAIL zero_run timeout hung=%0b exp=0", o.hung); end
    n_vec++; if (o.n_ce !== 0 || o.first_arm !== e.first_arm) begin n_err++; $display("FAIL zero_run ce=%0d arm_at=%0d exp ce=0 arm_at=%0d", o.n_ce, o.first_arm, e.first_arm); end
    n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL zero_run resp words=%0d err=%0b exp words=%0d err=%0b", o.words, o.err, e.words, e.err); end
  endtask

  task automatic test_ack_timeout();
    obs_t o;
    exp_t e;
    int   dly [3] = '{0, ACK_TO, ACK_TO + 1};
    foreach (dly[i]) begin
      e = model(1, 1'b1, dly[i], -1);
      run_cmd(1, 1'b1, dly[i], -1, 0, 0, 1'b0, o);
      n_vec++; if (o.hung !== 1'b0) begin n_err++; $display("FAIL ack_to[%0d] timeout hung=%0b exp=0", dly[i], o.hung); end
      n_vec++; if (o.n_bufop !== e.n_bufop || o.n_sen !== e.n_sen) begin n_err++; $display("FAIL ack_to[%0d] bufop=%0d sen=%0d exp bufop=%0d sen=%0d", dly[i], o.n_bufop, o.n_sen, e.n_bufop, e.n_sen); end
      n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL ack_to[%0d] resp words=%0d err=%0b exp words=%0d err=%0b", dly[i], o.words, o.err, e.words, e.err); end
    end
  endtask

  task automatic test_mismatch_backpressure();
    obs_t o;
    exp_t e;
    int   drop;
    drop = $urandom_range(0, WORDS - 1);
    e = model(2, 1'b1, 3, drop);
    run_cmd(2, 1'b1, 3, drop, 1, 10, 1'b1, o);
    n_vec++; if (o.hung !== 1'b0) begin n_err++; $display("FAIL mismatch timeout hung=%0b exp=0", o.hung); end
    n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL mismatch resp words=%0d err=%0b exp words=%0d err=%0b", o.words, o.err, e.words, e.err); end
    n_vec++; if (o.n_resp !== 11 || o.unstable !== 0) begin n_err++; $display("FAIL mismatch hold resp_cycles=%0d unstable=%0d exp 11/0", o.n_resp, o.unstable); end
    n_vec++; if (o.rdy_busy !== 0 || o.post_ok !== 1'b1) begin n_err++; $display("FAIL mismatch cmd_rdy rdy_busy=%0d post_ok=%0b exp 0/1", o.rdy_busy, o.post_ok); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   cyc, ack, drop, tail, rdy;
    bit   dump;
    for (int i = 0; i < 6; i++) begin
      cyc  = $urandom_range(0, 20);
      dump = 1'($urandom_range(0, 1));
      ack  = $urandom_range(1, ACK_TO + 6);
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, WORDS - 1) : -1;
      tail = $urandom_range(0, 4);
      rdy  = $urandom_range(0, 5);
      e = model(cyc, dump, ack, drop);
      run_cmd(cyc, dump, ack, drop, tail, rdy, 1'b1, o);
      n_vec++; if (o.hung !== 1'b0 || o.post_ok !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] completion hung=%0b post_ok=%0b exp 0/1", i, o.hung, o.post_ok); end
      n_vec++; if (o.n_ce !== e.n_ce || o.first_arm !== e.first_arm || o.n_bufop !== e.n_bufop || o.n_sen !== e.n_sen) begin n_err++; $display("FAIL b2b[%0d] phases ce=%0d arm_at=%0d bufop=%0d sen=%0d exp %0d/%0d/%0d/%0d", i, o.n_ce, o.first_arm, o.n_bufop, o.n_sen, e.n_ce, e.first_arm, e.n_bufop, e.n_sen); end
      n_vec++; if (o.words !== e.words || o.err !== e.err) begin n_err++; $display("FAIL b2b[%0d] resp words=%0d err=%0b exp words=%0d err=%0b", i, o.words, o.err, e.words, e.err); end
      n_vec++; if (o.viol !== 0 || o.unstable !== 0 || o.n_resp !== rdy + 1) begin n_err++; $display("FAIL b2b[%0d] protocol viol=%0d unstable=%0d resp_cycles=%0d exp 0/0/%0d", i, o.viol, o.unstable, o.n_resp, rdy + 1); end
    end
  endtask

  initial begin
    reset         = 1'b0;
    cmd_val       = 1'b0;
    cmd_cycles    = '0;
    cmd_dump      = 1'b0;
    resp_rdy      = 1'b0;
    buf_op_ack    = 1'b0;
    buf_op_commit = 1'b0;
    buf_scaning   = 1'b0;
    test_reset();
    test_run_only();
    test_full_dump();
    test_zero_run_dump();
    test_ack_timeout();
    test_mismatch_backpressure();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
